// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin register-bus arbiter; optional busy timeout via REG_ARB_TIMEOUT_EN
module reg_bus_arbiter #(
    parameter int NumReq        = 3,
    parameter int AW            = 7,
    parameter int DW            = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumReq-1:0]    req_i,
    input  logic [NumReq-1:0]    we_i,
    input  logic [NumReq*AW-1:0] addr_i,
    input  logic [NumReq*DW-1:0] wdata_i,
    output logic [NumReq-1:0]    gnt_o,
    output logic [NumReq-1:0]    rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic [NumReq-1:0]    err_o,
    output logic                 reg_we_o,
    output logic                 reg_re_o,
    output logic [AW-1:0]        reg_addr_o,
    output logic [DW-1:0]        reg_wdata_o,
    input  logic [DW-1:0]        reg_rdata_i,
    input  logic                 reg_busy_i
);
    localparam int IW = $clog2(NumReq);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] last_q, win_q, win_d, rr_win, rr_cand;
    logic          rr_found;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_d;
    logic          err_d;
    logic          timeout;

    // Search starts one past the last served requester and wraps.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NumReq; k++) begin
            rr_cand = IW'((int'(last_q) + k) % NumReq);
            if (!rr_found && req_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CW0 = $clog2(TimeoutCycles + 1);
    localparam int CW  = (CW0 < 8) ? 8 : ((CW0 > 16) ? 16 : CW0);

    logic [CW-1:0] tmo_cnt_q;

    assign timeout = (state_q == ISSUE) && reg_busy_i && (tmo_cnt_q == CW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (reg_busy_i) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end
    end
`else
    assign timeout = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        gnt_o   = '0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gnt_o[rr_win] = 1'b1;
                    win_d   = rr_win;
                    we_d    = we_i[rr_win];
                    addr_d  = addr_i[int'(rr_win)*AW +: AW];
                    wdata_d = wdata_i[int'(rr_win)*DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (!reg_busy_i) begin
                    rdata_d = we_q ? '0 : reg_rdata_i;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus-side outputs are registered from the next-state view so they align with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_q      <= IW'(NumReq - 1);
            win_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
            err_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if (state_q == RESP) begin
                last_q <= win_q;
            end
            rvalid_o    <= (state_d == RESP) ? (NumReq'(1) << win_d) : '0;
            err_o       <= (state_d == RESP && err_d) ? (NumReq'(1) << win_d) : '0;
            rdata_o     <= rdata_d;
            reg_we_o    <= (state_d == ISSUE) && we_d;
            reg_re_o    <= (state_d == ISSUE) && !we_d;
            reg_addr_o  <= (state_d == ISSUE) ? addr_d : '0;
            reg_wdata_o <= (state_d == ISSUE) ? wdata_d : '0;
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter against a transaction-level model
module tb_reg_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_i, we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, rvalid_o, err_o;
    logic [DW-1:0]   rdata_o;
    logic            reg_we_o, reg_re_o;
    logic [AW-1:0]   reg_addr_o;
    logic [DW-1:0]   reg_wdata_o;
    logic [DW-1:0]   reg_rdata_i;
    logic            reg_busy_i;

    reg_bus_arbiter #(.NumReq(N), .AW(AW), .DW(DW), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .reg_busy_i(reg_busy_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: one access in flight, described by flags and a record.
    int            m_last, m_who, m_wait, m_granted;
    bit            m_issue, m_resp, m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    task automatic model_reset();
        m_last = N - 1; m_who = 0; m_wait = 0; m_granted = -1;
        m_issue = 0; m_resp = 0; m_we = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic compare_all();
        logic [N-1:0] eg;
        int w;
        eg = '0;
        if (!m_issue && !m_resp) begin
            w = rr_pick(req_i);
            if (w >= 0) eg[w] = 1'b1;
        end
        check("gnt", gnt_o, eg);
        check("reg_we", reg_we_o, m_issue && m_we);
        check("reg_re", reg_re_o, m_issue && !m_we);
        check("reg_addr", reg_addr_o, m_issue ? m_addr : '0);
        check("reg_wdata", reg_wdata_o, m_issue ? m_wdata : '0);
        check("rvalid", rvalid_o, m_resp ? (N'(1) << m_who) : '0);
        check("rdata", rdata_o, m_resp ? m_rdata : '0);
        check("err", err_o, (m_resp && m_err) ? (N'(1) << m_who) : '0);
    endtask

    task automatic advance();
        int w;
        m_granted = -1;
        if (m_resp) begin
            m_last = m_who;
            m_resp = 0;
        end else if (m_issue) begin
            if (!reg_busy_i) begin
                m_issue = 0; m_resp = 1; m_err = 0;
                m_rdata = m_we ? '0 : reg_rdata_i;
            end
`ifdef REG_ARB_TIMEOUT_EN
            else if (m_wait == TO - 1) begin
                m_issue = 0; m_resp = 1; m_err = 1; m_rdata = '1;
            end
`endif
            else m_wait++;
        end else begin
            w = rr_pick(req_i);
            if (w >= 0) begin
                m_issue = 1; m_who = w; m_wait = 0; m_granted = w;
                m_we = we_i[w];
                m_addr = addr_i[w*AW +: AW];
                m_wdata = wdata_i[w*DW +: DW];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_all();
        advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '0; we_i = '0; reg_busy_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        model_reset();
        #1;
        rst_ni = 1'b1;
    endtask

    logic [N-1:0] pend;

    initial begin
        rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        reg_rdata_i = '0; reg_busy_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_strobes", {reg_we_o, reg_re_o}, 0);
        check("rst_addr_wdata", {reg_addr_o, reg_wdata_o}, 0);
        do_reset();

        // Single uncontended read by requester 1
        req_i = 3'b010; we_i = 3'b000; addr_i[AW +: AW] = 7'h04;
        reg_rdata_i = 32'h1234_5678;
        #1 check("rd_gnt_c0", gnt_o, 3'b010);
        tick();
        req_i = '0;
        check("rd_re_c1", reg_re_o, 1);
        check("rd_addr_c1", reg_addr_o, 7'h04);
        tick();
        check("rd_rvalid_c2", rvalid_o, 3'b010);
        check("rd_rdata_c2", rdata_o, 32'h1234_5678);
        tick();

        // Write from requester 0 with three busy cycles
        req_i = 3'b001; we_i = 3'b001; addr_i[0 +: AW] = 7'h08;
        wdata_i[0 +: DW] = 32'hCAFE_F00D; reg_busy_i = 1'b1;
        tick();
        req_i = '0;
        for (int i = 0; i < 3; i++) begin
            check("wr_we_busy", reg_we_o, 1);
            check("wr_addr_busy", reg_addr_o, 7'h08);
            check("wr_wdata_busy", reg_wdata_o, 32'hCAFE_F00D);
            tick();
        end
        reg_busy_i = 1'b0;
        check("wr_we_last", reg_we_o, 1);
        tick();
        check("wr_rvalid", rvalid_o, 3'b001);
        check("wr_rdata", rdata_o, 0);
        tick();

        // Contention from reset: grants rotate every third cycle
        do_reset();
        req_i = 3'b111; we_i = 3'b000;
        for (int g = 0; g < 6; g++) begin
            #1 check("rr_order", gnt_o, N'(1) << (g % N));
            tick(); tick(); tick();
        end
        req_i = '0;
        tick(); tick(); tick();

        // Async reset while a read strobe is held by busy
        do_reset();
        req_i = 3'b100; we_i = 3'b000; reg_busy_i = 1'b1;
        tick();
        req_i = '0;
        check("ar_re_before", reg_re_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("ar_re_dropped", reg_re_o, 0);
        check("ar_addr_dropped", reg_addr_o, 0);
        check("ar_rvalid", rvalid_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1; reg_busy_i = 1'b0;
        tick(); tick();
        req_i = 3'b111;
        #1 check("ar_first_gnt", gnt_o, 3'b001);
        tick();
        req_i = '0;
        tick(); tick();

        // Busy stuck high
        req_i = 3'b010; we_i = 3'b000; reg_busy_i = 1'b1;
        tick();
        req_i = '0;
        for (int i = 0; i < TO; i++) begin
            check("to_strobe", reg_re_o, 1);
            tick();
        end
`ifdef REG_ARB_TIMEOUT_EN
        check("to_rvalid", rvalid_o, 3'b010);
        check("to_err", err_o, 3'b010);
        check("to_rdata", rdata_o, 32'hFFFF_FFFF);
        tick();
        reg_busy_i = 1'b0; reg_rdata_i = 32'h0000_00A5;
        req_i = 3'b001;
        tick();
        req_i = '0;
        tick();
        check("to_next_rvalid", rvalid_o, 3'b001);
        check("to_next_err", err_o, 0);
        check("to_next_rdata", rdata_o, 32'h0000_00A5);
        tick();
`else
        for (int i = 0; i < 16; i++) begin
            check("nto_strobe", reg_re_o, 1);
            check("nto_err", err_o, 0);
            tick();
        end
        do_reset();
`endif

        // Randomized traffic against the model
        do_reset();
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    we_i[i] = 1'($urandom);
                    addr_i[i*AW +: AW] = AW'($urandom);
                    wdata_i[i*DW +: DW] = $urandom;
                end
            end
            req_i = pend;
            reg_busy_i = ($urandom % 3 == 0);
            reg_rdata_i = $urandom;
            tick();
            if (m_granted >= 0) pend[m_granted] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
